if_id_buf: RTL
==============

Name: if_id_buf

Overview:
- Consumer end of the fetch interface: accepts fetched {pc, pc4, inst} from the IF stage and presents them to ID in order.
- DEPTH-entry in-order FIFO decouples the fetch rate from decode stalls.
- Backpressures IF through `if_ready` (gates the PC update) and discards its whole contents on a redirect flush from EX.

Parameters:
- DEPTH, 2, number of buffered entries; power of two, at least 2.
- XLEN, 32, width of pc, pc4 and inst.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  IF presents a valid fetch this cycle.
- if_pc  in  XLEN  PC of the fetched instruction.
- if_pc4  in  XLEN  pc+4 from IF.
- if_inst  in  XLEN  instruction word.
- if_ready  out  1  buffer can accept a push; IF holds its PC when low.
- flush  in  1  EX redirect (branch/jump taken); discards all buffered entries.
- id_valid  out  1  head entry valid.
- id_pc  out  XLEN  head PC.
- id_pc4  out  XLEN  head pc+4.
- id_inst  out  XLEN  head instruction; NOP when `id_valid` is 0.
- id_ready  in  1  ID consumes the head this cycle.

Behaviour:
- Storage is a DEPTH-entry register array with rd_ptr, wr_ptr (log2 DEPTH bits, wrap modulo DEPTH) and count (log2 DEPTH + 1 bits).
- Reset: rd_ptr = wr_ptr = count = 0.
  - Outputs after reset: id_valid = 0, id_pc = 0, id_pc4 = 0, id_inst = NOP (0x00000013), if_ready = 1.
  - Storage contents are don't-care.
- Status signals:
  - if_ready = (count != DEPTH), derived from registered count only. There is no combinational path from id_ready to if_ready.
  - id_valid = (count != 0).
- Push = if_valid & if_ready & ~flush. Writes entry[wr_ptr] and increments wr_ptr.
- Pop = id_valid & id_ready & ~flush. Increments rd_ptr.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency: an entry pushed at edge N is visible on id_* from cycle N+1. There is no same-cycle bypass.
- Head outputs are read combinationally from entry[rd_ptr] when id_valid = 1. When empty, id_inst = NOP and id_pc = id_pc4 = 0.
- Full (count == DEPTH):
  - if_ready = 0, so an IF push is refused; IF must hold pc and if_valid.
  - A pop in the same cycle frees a slot, but if_ready only rises in the next cycle.
- Empty: id_ready is ignored and no underflow occurs.
- Flush: on the next edge rd_ptr = wr_ptr = count = 0.
  - Any push or pop in the same cycle is dropped.
  - Flush overrides everything except rst.
  - The cycle after a flush: id_valid = 0, if_ready = 1.
- rst mid-operation: identical to the reset state on the next edge, regardless of count or flush.
- Ordering: strict FIFO. Wrap-around of both pointers must preserve order.

Optional Feature:
- Macro: IFID_PERF_CNT_EN.
- When defined, adds three outputs: stall_cnt (32), flush_cnt (32), bubble_cnt (32).
  - stall_cnt: +1 each cycle with if_valid & ~if_ready.
  - flush_cnt: +1 each cycle flush = 1.
  - bubble_cnt: +1 each cycle with ~id_valid & id_ready.
  - All three reset to 0 on rst, are unaffected by flush, and wrap at 2^32.
- When undefined, the ports and counters are absent and core behaviour is identical.

Decomposition:
- Shared package / defines.vh holds:
  - NOP encoding 32'h00000013
  - XLEN default
  - reset PC value
- One sub-module is natural: if_id_perf, holding the three counters. It is instantiated only under IFID_PERF_CNT_EN.

Test Plan:
- Reset then idle → id_valid = 0, id_inst = 0x00000013, if_ready = 1 for 5 cycles.
- Push pc = 0x0, 0x4, 0x8 with id_ready = 1 → id_pc shows 0x0, 0x4, 0x8 on consecutive cycles, each one cycle after its push; id_pc4 = id_pc + 4.
- id_ready = 0, push 0x10 then 0x14 → count = 2, if_ready = 0.
  - Third fetch 0x18 is held by IF.
  - Raise id_ready: 0x10 pops, if_ready rises one cycle later, 0x18 enters.
  - Order seen at ID: 0x10, 0x14, 0x18.
- Buffer holds 2 entries; assert flush together with if_valid (pc = 0x20) and id_ready → next cycle id_valid = 0, count = 0, and 0x20 is not stored.
- Run 10 push/pop pairs so the pointers wrap several times → no entry is lost or duplicated and the id_pc sequence matches the push sequence.
- With IFID_PERF_CNT_EN: 3 refused-push cycles, 2 flushes, 4 empty cycles with id_ready = 1 → stall_cnt = 3, flush_cnt = 2, bubble_cnt = 4.

Source files
------------

// File: rtl/if_id_buf_pkg.sv
// Shared constants for the IF/ID fetch buffer: default data width, the
// instruction presented to decode when the buffer is empty, and the reset PC.
package if_id_buf_pkg;

    localparam int          XLEN_DEF = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_perf.sv
// Performance counters for the IF/ID buffer: fetch stalls, redirect flushes
// and decode bubbles. Free-running 32-bit counters that wrap; only rst clears them.
module if_id_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic        if_ready,
    input  logic        flush,
    input  logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] bubble_cnt
);

    logic [31:0] stall_q, flush_q, bubble_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            flush_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (if_valid && !if_ready) stall_q  <= stall_q + 32'd1;
            if (flush)                 flush_q  <= flush_q + 32'd1;
            if (!id_valid && id_ready) bubble_q <= bubble_q + 32'd1;
        end
    end

    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: rtl/if_id_buf.sv
// IF/ID decoupling FIFO: buffers fetched {pc, pc4, inst} in order for decode,
// backpressures fetch when full and drops everything on an EX redirect.
// Define IFID_PERF_CNT_EN to add the stall/flush/bubble counter outputs.
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_pc4,
    input  logic [XLEN-1:0] if_inst,
    output logic            if_ready,
    input  logic            flush,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc4,
    output logic [XLEN-1:0] id_inst,
    input  logic            id_ready
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt,
    output logic [31:0]     bubble_cnt
`endif
);

    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0]    CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [XLEN-1:0] pc4_q  [DEPTH];
    logic [XLEN-1:0] inst_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          push, pop;

    // Status comes from registered count only, so id_ready never reaches if_ready.
    assign if_ready = (count_q != FULL_CNT);
    assign id_valid = (count_q != '0);

    assign push = if_valid && if_ready && !flush;
    assign pop  = id_valid && id_ready && !flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; id_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr_q]   <= if_pc;
            pc4_q[wr_ptr_q]  <= if_pc4;
            inst_q[wr_ptr_q] <= if_inst;
        end
    end

    assign id_pc   = id_valid ? pc_q[rd_ptr_q]   : XLEN'(RESET_PC);
    assign id_pc4  = id_valid ? pc4_q[rd_ptr_q]  : XLEN'(RESET_PC);
    assign id_inst = id_valid ? inst_q[rd_ptr_q] : XLEN'(NOP_INST);

`ifdef IFID_PERF_CNT_EN
    if_id_perf u_perf (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .bubble_cnt (bubble_cnt)
    );
`endif

endmodule
